lif_neuron_scheduler: RTL and testbench

//  Time-multiplexes one shared combinational LIF `neuron` datapath across N_NEURONS virtual neurons.

---
 rtl/lif_neuron_scheduler.sv | 131 +++++++++++++
 tb/tb_lif_neuron_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes one external combinational LIF neuron datapath over N_NEURONS virtual neurons.
// Optional feature macro: LIF_REFRACTORY_EN adds a per-neuron refractory counter that gates dp_x.
module lif_neuron_scheduler #(
  parameter int N_NEURONS    = 4,
  parameter int X_W          = 2,
  parameter int W_W          = 2,
  parameter int U_W          = 3,
  parameter int REFRAC_STEPS = 2,
  localparam int A_W         = $clog2(N_NEURONS + 2),
  localparam int I_W         = $clog2(N_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [A_W-1:0]           cfg_addr,
  input  logic [U_W-1:0]           cfg_data,
  output logic                     cfg_ready,
  input  logic                     step_valid,
  input  logic [N_NEURONS*X_W-1:0] step_x,
  output logic                     step_ready,
  output logic                     spike_valid,
  output logic [N_NEURONS-1:0]     spike_vec,
  output logic [W_W-1:0]           dp_w,
  output logic [X_W-1:0]           dp_x,
  output logic [U_W-1:0]           dp_shift,
  output logic [U_W-1:0]           dp_prev_u,
  output logic [U_W-1:0]           dp_minus_teta,
  output logic                     dp_was_spike,
  input  logic [U_W-1:0]           dp_u,
  input  logic                     dp_spike
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [I_W-1:0]             idx_q;
  logic [N_NEURONS*W_W-1:0]   w_q;
  logic [N_NEURONS*U_W-1:0]   u_q;
  logic [N_NEURONS-1:0]       was_spike_q;
  logic [N_NEURONS*X_W-1:0]   x_lat_q;
  logic [U_W-1:0]             shift_q;
  logic [U_W-1:0]             minus_teta_q;
  logic [N_NEURONS-1:0]       spike_vec_q;
  logic                       accept;
  logic                       last;
  logic [X_W-1:0]             x_cur;

  assign accept        = (state_q == IDLE) && step_valid;
  assign last          = (idx_q == I_W'(N_NEURONS - 1));
  assign x_cur         = x_lat_q[idx_q*X_W +: X_W];

  assign cfg_ready     = (state_q == IDLE);
  assign step_ready    = (state_q == IDLE);
  assign spike_valid   = (state_q == DONE);
  assign spike_vec     = spike_vec_q;

  // Operands always reflect the neuron selected by idx (neuron 0 while idle).
  assign dp_w          = w_q[idx_q*W_W +: W_W];
  assign dp_shift      = shift_q;
  assign dp_prev_u     = u_q[idx_q*U_W +: U_W];
  assign dp_minus_teta = minus_teta_q;
  assign dp_was_spike  = was_spike_q[idx_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (step_valid) state_d = RUN;
      RUN:     if (last)       state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      w_q          <= {N_NEURONS{W_W'(1)}};
      u_q          <= '0;
      was_spike_q  <= '0;
      x_lat_q      <= '0;
      shift_q      <= U_W'(1);
      minus_teta_q <= U_W'(5);
      spike_vec_q  <= '0;
    end else begin
      state_q <= state_d;
      // Config writes land on the same edge as a step accept, so that step sees them.
      if ((state_q == IDLE) && cfg_we) begin
        if (cfg_addr < A_W'(N_NEURONS))
          w_q[cfg_addr*W_W +: W_W] <= cfg_data[W_W-1:0];
        else if (cfg_addr == A_W'(N_NEURONS))
          shift_q <= cfg_data;
        else if (cfg_addr == A_W'(N_NEURONS + 1))
          minus_teta_q <= cfg_data;
      end
      if (accept)
        x_lat_q <= step_x;
      if (state_q == RUN) begin
        u_q[idx_q*U_W +: U_W] <= dp_u;
        was_spike_q[idx_q]    <= dp_spike;
        spike_vec_q[idx_q]    <= dp_spike;
        idx_q                 <= last ? '0 : idx_q + 1'b1;
      end
    end
  end

`ifdef LIF_REFRACTORY_EN
  localparam int R_W = $clog2(REFRAC_STEPS + 1);

  logic [N_NEURONS*R_W-1:0] ref_q;
  logic [R_W-1:0]           ref_cur;

  assign ref_cur = ref_q[idx_q*R_W +: R_W];
  assign dp_x    = (ref_cur != '0) ? '0 : x_cur;

  // A fresh spike reloads the counter even if it was still counting down.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
    end else if (state_q == RUN) begin
      if (dp_spike)
        ref_q[idx_q*R_W +: R_W] <= R_W'(REFRAC_STEPS);
      else if (ref_cur != '0)
        ref_q[idx_q*R_W +: R_W] <= ref_cur - 1'b1;
    end
  end
`else
  assign dp_x = x_cur;
`endif

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Bench for lif_neuron_scheduler: supplies a behavioural neuron datapath and checks spike vectors
// against a per-step array model; table vectors, random steps and hand-written corner sequences.
module tb_lif_neuron_scheduler;
  localparam int N   = 4;
  localparam int XW  = 2;
  localparam int UW  = 3;
  localparam int AW  = 3;
  localparam int NX  = N * XW;
  localparam int REF = 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          cfg_we = 0;
  logic [AW-1:0] cfg_addr = '0;
  logic [UW-1:0] cfg_data = '0;
  logic          cfg_ready;
  logic          step_valid = 0;
  logic [NX-1:0] step_x = '0;
  logic          step_ready;
  logic          spike_valid;
  logic [N-1:0]  spike_vec;
  logic [1:0]    dp_w;
  logic [XW-1:0] dp_x;
  logic [UW-1:0] dp_shift, dp_prev_u, dp_minus_teta, dp_u;
  logic          dp_was_spike, dp_spike;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_neuron_scheduler #(.N_NEURONS(N), .X_W(XW), .W_W(2), .U_W(UW), .REFRAC_STEPS(REF)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .step_valid(step_valid), .step_x(step_x), .step_ready(step_ready),
    .spike_valid(spike_valid), .spike_vec(spike_vec), .dp_w(dp_w), .dp_x(dp_x),
    .dp_shift(dp_shift), .dp_prev_u(dp_prev_u), .dp_minus_teta(dp_minus_teta),
    .dp_was_spike(dp_was_spike), .dp_u(dp_u), .dp_spike(dp_spike));

  // Neuron law used by the attached datapath: reset after a spike, leak by shift, add w*x, clip at 7.
  function automatic int neuron_next(input int prev, input int ws, input int w, input int x, input int sh);
    int b;
    int t;
    b = (ws != 0) ? 0 : prev;
    t = (b >> sh) + w * x;
    if (t > 7) t = 7;
    return t;
  endfunction

  assign dp_u     = UW'(neuron_next(int'(dp_prev_u), int'(dp_was_spike), int'(dp_w), int'(dp_x), int'(dp_shift)));
  assign dp_spike = int'(dp_u) >= int'(dp_minus_teta);

  // Reference state, one entry per virtual neuron.
  int mu[N], mws[N], mw[N], mref[N];
  int mshift, mmt;
  logic [N-1:0] mvec;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin mu[i] = 0; mws[i] = 0; mw[i] = 1; mref[i] = 0; end
    mshift = 1; mmt = 5; mvec = '0;
  endtask

  task automatic model_cfg(input int addr, input int data);
    if (addr < N) mw[addr] = data & 3;
    else if (addr == N) mshift = data;
    else if (addr == N + 1) mmt = data;
  endtask

  task automatic model_step(input logic [NX-1:0] x, output logic [N-1:0] v);
    int xi, t;
    v = '0;
    for (int i = 0; i < N; i++) begin
      xi = int'((x >> (i * XW)) & 2'b11);
`ifdef LIF_REFRACTORY_EN
      if (mref[i] != 0) begin xi = 0; mref[i]--; end
`endif
      t = neuron_next(mu[i], mws[i], mw[i], xi, mshift);
      v[i] = (t >= mmt);
`ifdef LIF_REFRACTORY_EN
      if (v[i]) mref[i] = REF;
`endif
      mu[i] = t;
      mws[i] = int'(v[i]);
    end
    mvec = v;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  int x0_seen, mt_seen;

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!step_ready && guard < 50) begin @(negedge clk); guard++; end
    chk("idle_wait", int'(step_ready), 1);
  endtask

  task automatic do_cfg(input int addr, input int data);
    wait_idle();
    cfg_we = 1; cfg_addr = AW'(addr); cfg_data = UW'(data);
    @(negedge clk);
    cfg_we = 0;
    model_cfg(addr, data);
  endtask

  task automatic do_step(input logic [NX-1:0] x, input logic we, input int addr, input int data,
                         output logic [N-1:0] got);
    int first, hi;
    logic [N-1:0] expv, prev;
    wait_idle();
    cfg_we = we; cfg_addr = AW'(addr); cfg_data = UW'(data);
    step_valid = 1; step_x = x;
    @(posedge clk);
    prev = mvec;
    if (we) model_cfg(addr, data);
    model_step(x, expv);
    first = -1; hi = 0; got = '0;
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        cfg_we = 0; step_valid = 0;
        x0_seen = int'(dp_x); mt_seen = int'(dp_minus_teta);
        chk("vec_hold_on_accept", int'(spike_vec), int'(prev));
      end
      if (spike_valid) begin
        hi++;
        if (first < 0) begin first = k; got = spike_vec; end
      end
    end
    chk("spike_valid_cycle", first, N + 1);
    chk("spike_valid_width", hi, 1);
    chk("spike_vec", int'(got), int'(expv));
  endtask

  typedef struct { logic [NX-1:0] x; logic [N-1:0] vec; } vec_t;
  vec_t tbl[6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] got, v;
    int sv_hi, nacc, last_acc;
    int acc[$];
    logic [N-1:0] expq[$];
    logic [NX-1:0] xh;

    tbl[0] = '{8'hFF, 4'b0000};
    tbl[1] = '{8'hFF, 4'b0000};
    tbl[2] = '{8'h73, 4'b0101};
    tbl[3] = '{8'hFF, 4'b0000};
    tbl[4] = '{8'hAA, 4'b0000};
    tbl[5] = '{8'hCF, 4'b1010};

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    sv_hi = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (spike_valid) sv_hi++; end
    chk("rst_cfg_ready", int'(cfg_ready), 1);
    chk("rst_step_ready", int'(step_ready), 1);
    chk("rst_spike_valid_hi", sv_hi, 0);
    chk("rst_minus_teta", int'(dp_minus_teta), 5);
    chk("rst_shift", int'(dp_shift), 1);
    chk("rst_w0", int'(dp_w), 1);
    chk("rst_prev_u", int'(dp_prev_u), 0);
    chk("rst_spike_vec", int'(spike_vec), 0);

    for (int i = 0; i < 6; i++) begin
      do_step(tbl[i].x, 1'b0, 0, 0, got);
`ifndef LIF_REFRACTORY_EN
      chk($sformatf("table_vec%0d", i), int'(got), int'(tbl[i].vec));
`endif
    end

    for (int i = 0; i < 25; i++) begin
      do_step(NX'($urandom), ($urandom_range(0, 9) < 3), $urandom_range(0, 7), $urandom_range(0, 7), got);
    end

    do_step('0, 1'b1, N + 1, 3, got);
    chk("minus_teta_in_run", mt_seen, 3);

    // Held step_valid: accepts spaced by N+2; a config write during RUN is dropped.
    wait_idle();
    xh = NX'($urandom);
    for (int c = 0; c < 4 * (N + 2); c++) begin
      @(negedge clk);
      if (c == 0) begin step_valid = 1; step_x = xh; end
      if (spike_valid) begin
        if (expq.size() > 0) chk("held_vec", int'(spike_vec), int'(expq.pop_front()));
        else chk("held_extra_spike", 1, 0);
      end
      cfg_we = 0;
      if (c == 3) begin
        chk("cfg_ready_in_run", int'(cfg_ready), 0);
        cfg_we = 1; cfg_addr = AW'(N); cfg_data = UW'(mshift + 1);
      end
      if (step_ready) begin acc.push_back(c); model_step(xh, v); expq.push_back(v); end
    end
    @(negedge clk);
    step_valid = 0; cfg_we = 0;
    for (int c = 0; c < N + 3; c++) begin
      if (spike_valid) begin
        if (expq.size() > 0) chk("held_vec", int'(spike_vec), int'(expq.pop_front()));
        else chk("held_extra_spike", 1, 0);
      end
      @(negedge clk);
    end
    chk("held_pending", expq.size(), 0);
    chk("held_accepts", acc.size(), 4);
    last_acc = acc.pop_front();
    while (acc.size() > 0) begin
      nacc = acc.pop_front();
      chk("held_period", nacc - last_acc, N + 2);
      last_acc = nacc;
    end
    chk("cfg_dropped_shift", int'(dp_shift), mshift);

    // Reset asserted while idx=1: everything back to reset values, no pulse afterwards.
    do_cfg(0, 1);
    wait_idle();
    step_valid = 1; step_x = NX'(3);
    @(posedge clk);
    @(negedge clk);
    step_valid = 0;
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("midrst_step_ready", int'(step_ready), 1);
    chk("midrst_prev_u0", int'(dp_prev_u), 0);
    chk("midrst_was_spike0", int'(dp_was_spike), 0);
    chk("midrst_minus_teta", int'(dp_minus_teta), 5);
    chk("midrst_shift", int'(dp_shift), 1);
    repeat (2) @(negedge clk);
    rst_n = 1;
    model_reset();
    sv_hi = 0;
    for (int c = 0; c < N + 3; c++) begin @(negedge clk); if (spike_valid) sv_hi++; end
    chk("midrst_no_pulse", sv_hi, 0);
    chk("midrst_spike_vec", int'(spike_vec), 0);

`ifdef LIF_REFRACTORY_EN
    for (int s = 1; s <= 6; s++) begin
      do_step(NX'(3), 1'b0, 0, 0, got);
      if (s == 3) chk("refr_spike", int'(got[0]), 1);
      if (s == 4 || s == 5) begin
        chk($sformatf("refr_x_gated%0d", s), x0_seen, 0);
        chk($sformatf("refr_no_spike%0d", s), int'(got[0]), 0);
      end
      if (s == 6) chk("refr_x_pass", x0_seen, 3);
    end
`else
    do_step(NX'(3), 1'b0, 0, 0, got);
    chk("x_pass_idx0", x0_seen, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
